// File: rtl/issue_pkg.sv
// Types, widths and helpers shared between the issue stage and the writeback/return block.
package issue_pkg;

  localparam int LANES   = 4;
  localparam int DES_W   = 4;
  localparam int OP_W    = 4;
  localparam int BID_W   = 3;
  localparam int REG_NUM = 16;
  localparam int MAX_LAT = 3;

  typedef struct packed {
    logic             vld;
    logic [DES_W-1:0] des;
    logic [BID_W-1:0] bid;
  } wb_entry_t;

  function automatic logic [1:0] op_latency(input logic [OP_W-1:0] op);
    if (op < 4'd8)       return 2'd1;
    else if (op < 4'd12) return 2'd2;
    else                 return 2'd3;
  endfunction

  function automatic logic [REG_NUM-1:0] des_onehot(input logic [DES_W-1:0] des);
    logic [REG_NUM-1:0] r;
    r      = '0;
    r[des] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/wb_lane.sv
// One return lane: a MAX_LAT-deep delay line with latency-indexed insertion, collision and squash.
module wb_lane
  import issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  input  logic [DES_W-1:0]   in_des,
  input  logic [OP_W-1:0]    in_op,
  input  logic [BID_W-1:0]   in_bid,
  input  logic               sq_vld,
  input  logic [BID_W-1:0]   sq_id,
  output logic               head_vld,
  output logic [DES_W-1:0]   head_des,
  output logic [MAX_LAT-1:0] free,
  output logic               collision,
  output logic [REG_NUM-1:0] sq_mask
);

  wb_entry_t  slots [MAX_LAT];
  wb_entry_t  nxt   [MAX_LAT];
  logic [1:0] slot_idx;

  assign head_vld = slots[0].vld;
  assign head_des = slots[0].des;
  assign slot_idx = op_latency(in_op) - 2'd1;

  // A latency-L issue lands in slot L-1 after the shift, i.e. where slot L is heading.
  always_comb begin
    for (int k = 0; k < MAX_LAT-1; k++) free[k] = !slots[k+1].vld;
    free[MAX_LAT-1] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < MAX_LAT-1; k++) nxt[k] = slots[k+1];
    nxt[MAX_LAT-1] = '0;
    sq_mask   = '0;
    collision = 1'b0;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (sq_vld && nxt[k].vld && nxt[k].bid == sq_id) begin
        sq_mask = sq_mask | des_onehot(nxt[k].des);
        nxt[k]  = '0;
      end
    end
    // A squashed incoming instruction never claims its slot, so it cannot collide.
    if (in_vld) begin
      if (sq_vld && in_bid == sq_id)
        sq_mask = sq_mask | des_onehot(in_des);
      else if (!free[slot_idx])
        collision = 1'b1;
      else
        nxt[slot_idx] = '{vld: 1'b1, des: in_des, bid: in_bid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAX_LAT; k++) slots[k] <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT; k++) slots[k] <= nxt[k];
    end
  end

endmodule

// File: rtl/writeback_return.sv
// Issue-interface back end: per-lane fixed-latency return plus mispredict flush broadcast.
module writeback_return
  import issue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               iq_out_1_vld,
  input  logic [DES_W-1:0]   iq_out_1_des,
  input  logic [OP_W-1:0]    iq_out_1_op,
  input  logic [BID_W-1:0]   iq_out_1_bid,
  input  logic               iq_out_2_vld,
  input  logic [DES_W-1:0]   iq_out_2_des,
  input  logic [OP_W-1:0]    iq_out_2_op,
  input  logic [BID_W-1:0]   iq_out_2_bid,
  input  logic               iq_out_3_vld,
  input  logic [DES_W-1:0]   iq_out_3_des,
  input  logic [OP_W-1:0]    iq_out_3_op,
  input  logic [BID_W-1:0]   iq_out_3_bid,
  input  logic               iq_out_4_vld,
  input  logic [DES_W-1:0]   iq_out_4_des,
  input  logic [OP_W-1:0]    iq_out_4_op,
  input  logic [BID_W-1:0]   iq_out_4_bid,
  input  logic               br_resolve_vld,
  input  logic [BID_W-1:0]   br_resolve_id,
  input  logic               br_mispredict,
  output logic               ins_back_1_vld,
  output logic [DES_W-1:0]   ins_back_1_des,
  output logic               ins_back_2_vld,
  output logic [DES_W-1:0]   ins_back_2_des,
  output logic               ins_back_3_vld,
  output logic [DES_W-1:0]   ins_back_3_des,
  output logic               ins_back_4_vld,
  output logic [DES_W-1:0]   ins_back_4_des,
  output logic [MAX_LAT-1:0] lane_1_free,
  output logic [MAX_LAT-1:0] lane_2_free,
  output logic [MAX_LAT-1:0] lane_3_free,
  output logic [MAX_LAT-1:0] lane_4_free,
  output logic               flush_en,
  output logic [BID_W-1:0]   flush_id,
  output logic [REG_NUM-1:0] flush_reg,
  output logic               err_collision
);

  logic [LANES-1:0]   in_vld;
  logic [DES_W-1:0]   in_des  [LANES];
  logic [OP_W-1:0]    in_op   [LANES];
  logic [BID_W-1:0]   in_bid  [LANES];
  logic [LANES-1:0]   head_vld;
  logic [DES_W-1:0]   head_des [LANES];
  logic [MAX_LAT-1:0] free     [LANES];
  logic [LANES-1:0]   coll;
  logic [REG_NUM-1:0] mask     [LANES];
  logic [REG_NUM-1:0] mask_or;
  logic               mispredict;

  assign in_vld    = {iq_out_4_vld, iq_out_3_vld, iq_out_2_vld, iq_out_1_vld};
  assign in_des[0] = iq_out_1_des;
  assign in_des[1] = iq_out_2_des;
  assign in_des[2] = iq_out_3_des;
  assign in_des[3] = iq_out_4_des;
  assign in_op[0]  = iq_out_1_op;
  assign in_op[1]  = iq_out_2_op;
  assign in_op[2]  = iq_out_3_op;
  assign in_op[3]  = iq_out_4_op;
  assign in_bid[0] = iq_out_1_bid;
  assign in_bid[1] = iq_out_2_bid;
  assign in_bid[2] = iq_out_3_bid;
  assign in_bid[3] = iq_out_4_bid;

  assign mispredict = br_resolve_vld && br_mispredict;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    wb_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (in_vld[n]),
      .in_des    (in_des[n]),
      .in_op     (in_op[n]),
      .in_bid    (in_bid[n]),
      .sq_vld    (mispredict),
      .sq_id     (br_resolve_id),
      .head_vld  (head_vld[n]),
      .head_des  (head_des[n]),
      .free      (free[n]),
      .collision (coll[n]),
      .sq_mask   (mask[n])
    );
  end

  assign ins_back_1_vld = head_vld[0];
  assign ins_back_2_vld = head_vld[1];
  assign ins_back_3_vld = head_vld[2];
  assign ins_back_4_vld = head_vld[3];
  assign ins_back_1_des = head_des[0];
  assign ins_back_2_des = head_des[1];
  assign ins_back_3_des = head_des[2];
  assign ins_back_4_des = head_des[3];
  assign lane_1_free    = free[0];
  assign lane_2_free    = free[1];
  assign lane_3_free    = free[2];
  assign lane_4_free    = free[3];

  always_comb begin
    mask_or = '0;
    for (int n = 0; n < LANES; n++) mask_or = mask_or | mask[n];
  end

  // Flush outputs are a registered one-cycle pulse; id and mask are zeroed between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_en      <= 1'b0;
      flush_id      <= '0;
      flush_reg     <= '0;
      err_collision <= 1'b0;
    end else begin
      flush_en      <= mispredict;
      flush_id      <= mispredict ? br_resolve_id : '0;
      flush_reg     <= mispredict ? mask_or : '0;
      err_collision <= err_collision | (|coll);
    end
  end

endmodule

// File: tb/tb_writeback_return.sv
// Self-checking bench: directed scenarios plus randomized traffic against a completion-time model.
module tb_writeback_return;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      iv;
  logic [3:0][3:0] ides;
  logic [3:0][3:0] iop;
  logic [3:0][2:0] ibid;
  logic            rv;
  logic [2:0]      rid;
  logic            mp;
  logic [3:0]      ovld;
  logic [3:0][3:0] odes;
  logic [3:0][2:0] ofree;
  logic            fen;
  logic [2:0]      fid;
  logic [15:0]     freg;
  logic            err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_return dut (
    .clk(clk), .rst(rst),
    .iq_out_1_vld(iv[0]), .iq_out_1_des(ides[0]), .iq_out_1_op(iop[0]), .iq_out_1_bid(ibid[0]),
    .iq_out_2_vld(iv[1]), .iq_out_2_des(ides[1]), .iq_out_2_op(iop[1]), .iq_out_2_bid(ibid[1]),
    .iq_out_3_vld(iv[2]), .iq_out_3_des(ides[2]), .iq_out_3_op(iop[2]), .iq_out_3_bid(ibid[2]),
    .iq_out_4_vld(iv[3]), .iq_out_4_des(ides[3]), .iq_out_4_op(iop[3]), .iq_out_4_bid(ibid[3]),
    .br_resolve_vld(rv), .br_resolve_id(rid), .br_mispredict(mp),
    .ins_back_1_vld(ovld[0]), .ins_back_1_des(odes[0]),
    .ins_back_2_vld(ovld[1]), .ins_back_2_des(odes[1]),
    .ins_back_3_vld(ovld[2]), .ins_back_3_des(odes[2]),
    .ins_back_4_vld(ovld[3]), .ins_back_4_des(odes[3]),
    .lane_1_free(ofree[0]), .lane_2_free(ofree[1]), .lane_3_free(ofree[2]), .lane_4_free(ofree[3]),
    .flush_en(fen), .flush_id(fid), .flush_reg(freg), .err_collision(err)
  );

  // Reference model: each in-flight instruction is just (lane, completion cycle, des, bid).
  typedef struct {
    int lane;
    int due;
    int des;
    int bid;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  bit          m_fen;
  int          m_fid;
  bit [15:0]   m_freg;
  bit          m_err;

  function automatic int lat_of(int op);
    if (op < 8)  return 1;
    if (op < 12) return 2;
    return 3;
  endfunction

  function automatic bit m_busy(int lane, int due);
    foreach (pend[i]) if (pend[i].lane == lane && pend[i].due == due) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_des(int lane, int due);
    foreach (pend[i]) if (pend[i].lane == lane && pend[i].due == due) return pend[i].des;
    return 0;
  endfunction

  function automatic logic [2:0] m_free(int lane);
    logic [2:0] f;
    for (int k = 0; k < 3; k++) f[k] = !m_busy(lane, cyc + k + 1);
    return f;
  endfunction

  task automatic model_edge();
    bit        mis;
    bit [15:0] mask;
    bit        occ [4][4];
    int        l;
    if (rst) begin
      pend.delete();
      m_fen = 0; m_fid = 0; m_freg = '0; m_err = 0;
      return;
    end
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due <= cyc) pend.delete(i);
    for (int ln = 0; ln < 4; ln++)
      for (int d = 1; d < 4; d++) occ[ln][d] = m_busy(ln, cyc + d);
    mis  = rv && mp;
    mask = '0;
    if (mis) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].bid == int'(rid)) begin
          mask[pend[i].des] = 1'b1;
          pend.delete(i);
        end
      end
    end
    for (int ln = 0; ln < 4; ln++) begin
      if (iv[ln]) begin
        l = lat_of(int'(iop[ln]));
        if (mis && ibid[ln] == rid) mask[ides[ln]] = 1'b1;
        else if (occ[ln][l]) m_err = 1;
        else pend.push_back('{lane: ln, due: cyc + l, des: int'(ides[ln]), bid: int'(ibid[ln])});
      end
    end
    m_fen  = mis;
    m_fid  = int'(rid);
    m_freg = mask;
  endtask

  task automatic step();
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    iv = '0; ides = '0; iop = '0; ibid = '0;
    rv = 1'b0; rid = '0; mp = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic issue(int lane, int op, int des, int bid);
    iv[lane]   = 1'b1;
    iop[lane]  = 4'(op);
    ides[lane] = 4'(des);
    ibid[lane] = 3'(bid);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ovld !== 4'b0) begin n_err++; $display("[TB] FAIL reset_vld: got %b expected 0000", ovld); end
    n_cmp++; if (odes !== '0) begin n_err++; $display("[TB] FAIL reset_des: got %h expected 0", odes); end
    n_cmp++; if (ofree !== {4{3'b111}}) begin n_err++; $display("[TB] FAIL reset_free: got %h expected fff", ofree); end
    n_cmp++; if ({fen, fid, freg, err} !== '0) begin n_err++; $display("[TB] FAIL reset_flush: got en=%b id=%0d reg=%h err=%b expected zeros", fen, fid, freg, err); end
  endtask

  task automatic test_single();
    issue(0, 2, 5, 0);
    n_cmp++; if (ofree[0] !== 3'b111) begin n_err++; $display("[TB] FAIL single_free0: got %b expected 111", ofree[0]); end
    step();
    idle_inputs();
    n_cmp++; if (ovld[0] !== 1'b1 || odes[0] !== 4'd5) begin n_err++; $display("[TB] FAIL single_back: got vld=%b des=%0d expected vld=1 des=5", ovld[0], odes[0]); end
    n_cmp++; if (ofree[0] !== 3'b111) begin n_err++; $display("[TB] FAIL single_free1: got %b expected 111", ofree[0]); end
    step();
    n_cmp++; if (ovld[0] !== 1'b0) begin n_err++; $display("[TB] FAIL single_once: got vld=%b expected 0", ovld[0]); end
  endtask

  task automatic test_all_lanes();
    issue(0, 4'h0, 1, 0); issue(1, 4'h8, 2, 0); issue(2, 4'hC, 3, 0); issue(3, 4'h0, 4, 0);
    step();
    idle_inputs();
    n_cmp++; if (ovld !== 4'b1001 || odes[0] !== 4'd1 || odes[3] !== 4'd4) begin n_err++; $display("[TB] FAIL all_c1: got vld=%b des1=%0d des4=%0d expected 1001 1 4", ovld, odes[0], odes[3]); end
    step();
    n_cmp++; if (ovld !== 4'b0010 || odes[1] !== 4'd2) begin n_err++; $display("[TB] FAIL all_c2: got vld=%b des2=%0d expected 0010 2", ovld, odes[1]); end
    step();
    n_cmp++; if (ovld !== 4'b0100 || odes[2] !== 4'd3) begin n_err++; $display("[TB] FAIL all_c3: got vld=%b des3=%0d expected 0100 3", ovld, odes[2]); end
    step();
  endtask

  task automatic test_collision();
    issue(1, 4'hC, 7, 0);
    step();
    idle_inputs();
    n_cmp++; if (ofree[1][1] !== 1'b0) begin n_err++; $display("[TB] FAIL coll_free: got %b expected bit1=0", ofree[1]); end
    issue(1, 4'h8, 9, 0);
    step();
    idle_inputs();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("[TB] FAIL coll_err: got %b expected 1", err); end
    n_cmp++; if (ovld[1] !== 1'b0) begin n_err++; $display("[TB] FAIL coll_c2: got vld=%b expected 0", ovld[1]); end
    step();
    n_cmp++; if (ovld[1] !== 1'b1 || odes[1] !== 4'd7) begin n_err++; $display("[TB] FAIL coll_c3: got vld=%b des=%0d expected vld=1 des=7", ovld[1], odes[1]); end
    step();
    n_cmp++; if (ovld[1] !== 1'b0 || err !== 1'b1) begin n_err++; $display("[TB] FAIL coll_c4: got vld=%b err=%b expected vld=0 err=1", ovld[1], err); end
  endtask

  task automatic test_squash();
    do_reset();
    issue(2, 4'hC, 6, 2); issue(3, 4'h8, 10, 2); issue(0, 4'h8, 3, 1);
    step();
    idle_inputs();
    rv = 1'b1; mp = 1'b1; rid = 3'd2;
    step();
    idle_inputs();
    n_cmp++; if (fen !== 1'b1 || fid !== 3'd2 || freg !== 16'h0440) begin n_err++; $display("[TB] FAIL squash_flush: got en=%b id=%0d reg=%h expected 1 2 0440", fen, fid, freg); end
    n_cmp++; if (ovld !== 4'b0001 || odes[0] !== 4'd3) begin n_err++; $display("[TB] FAIL squash_c2: got vld=%b des1=%0d expected 0001 3", ovld, odes[0]); end
    step();
    n_cmp++; if (fen !== 1'b0 || ovld !== 4'b0000) begin n_err++; $display("[TB] FAIL squash_c3: got en=%b vld=%b expected 0 0000", fen, ovld); end
  endtask

  task automatic test_back_to_back();
    issue(0, 4'hC, 1, 1); issue(1, 4'hC, 2, 2);
    step();
    idle_inputs();
    rv = 1'b1; mp = 1'b1; rid = 3'd1;
    step();
    rid = 3'd2;
    n_cmp++; if (fen !== 1'b1 || fid !== 3'd1 || freg !== 16'h0002) begin n_err++; $display("[TB] FAIL b2b_first: got en=%b id=%0d reg=%h expected 1 1 0002", fen, fid, freg); end
    step();
    idle_inputs();
    n_cmp++; if (fen !== 1'b1 || fid !== 3'd2 || freg !== 16'h0004) begin n_err++; $display("[TB] FAIL b2b_second: got en=%b id=%0d reg=%h expected 1 2 0004", fen, fid, freg); end
    n_cmp++; if (ovld !== 4'b0000) begin n_err++; $display("[TB] FAIL b2b_noback: got vld=%b expected 0000", ovld); end
    rv = 1'b1; mp = 1'b0; rid = 3'd2;
    step();
    idle_inputs();
    n_cmp++; if (fen !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_nomis: got en=%b expected 0", fen); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    issue(0, 4'hC, 1, 0); issue(1, 4'hC, 2, 0); issue(2, 4'h8, 3, 0);
    step();
    idle_inputs();
    issue(0, 4'h8, 4, 0);
    step();
    idle_inputs();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_err_set: got %b expected 1", err); end
    rst = 1'b1;
    issue(3, 4'h0, 5, 0);
    step();
    rst = 1'b0;
    idle_inputs();
    n_cmp++; if ({ovld, odes, fen, fid, freg, err} !== '0 || ofree !== {4{3'b111}}) begin n_err++; $display("[TB] FAIL midrst_zero: got vld=%b des=%h err=%b free=%h expected zeros/fff", ovld, odes, err, ofree); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (ovld !== 4'b0000) begin n_err++; $display("[TB] FAIL midrst_quiet: got vld=%b expected 0000", ovld); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int ln = 0; ln < 4; ln++) begin
        iv[ln]   = $urandom_range(0, 1) == 1;
        iop[ln]  = 4'($urandom_range(0, 15));
        ides[ln] = 4'($urandom_range(0, 15));
        ibid[ln] = 3'($urandom_range(0, 3));
      end
      rv  = $urandom_range(0, 3) == 0;
      mp  = $urandom_range(0, 1) == 1;
      rid = 3'($urandom_range(0, 3));
      step();
      for (int ln = 0; ln < 4; ln++) begin
        n_cmp++; if (ovld[ln] !== m_busy(ln, cyc)) begin n_err++; $display("[TB] FAIL rnd_vld lane%0d cyc%0d: got %b expected %b", ln + 1, cyc, ovld[ln], m_busy(ln, cyc)); end
        if (m_busy(ln, cyc)) begin
          n_cmp++; if (odes[ln] !== 4'(m_des(ln, cyc))) begin n_err++; $display("[TB] FAIL rnd_des lane%0d cyc%0d: got %0d expected %0d", ln + 1, cyc, odes[ln], m_des(ln, cyc)); end
        end
        n_cmp++; if (ofree[ln] !== m_free(ln)) begin n_err++; $display("[TB] FAIL rnd_free lane%0d cyc%0d: got %b expected %b", ln + 1, cyc, ofree[ln], m_free(ln)); end
      end
      n_cmp++; if (fen !== m_fen) begin n_err++; $display("[TB] FAIL rnd_flush_en cyc%0d: got %b expected %b", cyc, fen, m_fen); end
      if (m_fen) begin
        n_cmp++; if (fid !== 3'(m_fid) || freg !== m_freg) begin n_err++; $display("[TB] FAIL rnd_flush cyc%0d: got id=%0d reg=%h expected id=%0d reg=%h", cyc, fid, freg, m_fid, m_freg); end
      end
      n_cmp++; if (err !== m_err) begin n_err++; $display("[TB] FAIL rnd_err cyc%0d: got %b expected %b", cyc, err, m_err); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_lanes();
    test_collision();
    test_squash();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
